// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one level req/ack memory read per fetch and presents the word as ir.
// Redirect flushes any in-flight fetch; a request already on the bus is drained before the next one can issue.
module ifetch_unit #(
  parameter int                    PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                IM_enable,
  input  logic                IM_read,
  input  logic                enable_fetch,
  input  logic                enable_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                im_req,
  output logic [PC_WIDTH-1:0] im_addr,
  input  logic                im_ack,
  input  logic [31:0]         im_rdata,
  output logic [31:0]         ir,
  output logic                ir_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_im_addr;
  logic                r_im_req;
  logic [31:0]         r_ir;
  logic                r_ir_valid;
  logic [31:0]         r_buf;
  logic                r_pending;

  logic                w_ack;
  logic                w_start;
  logic                w_req_clr;
  logic                w_load_ir_mem;
  logic                w_load_ir_buf;
  logic                w_load_buf;
  logic                w_pend_set;
  logic                w_pend_clr;
  logic [PC_WIDTH-1:0] w_redirect_tgt;

  // Acks only count while a request is actually on the bus.
  assign w_ack          = im_ack & r_im_req;
  assign w_redirect_tgt = redirect_pc & ~(PC_WIDTH'(3));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_req_clr     = 1'b0;
    w_load_ir_mem = 1'b0;
    w_load_ir_buf = 1'b0;
    w_load_buf    = 1'b0;
    w_pend_set    = 1'b0;
    w_pend_clr    = redirect_valid;
    case (r_state)
      S_IDLE: begin
        if (!redirect_valid && IM_enable && IM_read) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // An unacked request cannot be withdrawn, so it is drained instead.
          if (w_ack) begin
            w_req_clr   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (w_ack) begin
          w_req_clr = 1'b1;
          if (r_pending || enable_fetch) begin
            w_load_ir_mem = 1'b1;
            w_pend_clr    = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_load_buf  = 1'b1;
            w_state_nxt = S_FULL;
          end
        end else if (enable_fetch) begin
          w_pend_set = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          w_state_nxt = S_IDLE;
        end else if (enable_fetch) begin
          w_load_ir_buf = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_ack) begin
          w_req_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_im_addr  <= '0;
      r_im_req   <= 1'b0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_buf      <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (redirect_valid)  r_pc <= w_redirect_tgt;
      else if (enable_pc)  r_pc <= r_pc + PC_WIDTH'(4);

      if (w_start) begin
        r_im_req  <= 1'b1;
        r_im_addr <= r_pc;
      end else if (w_req_clr) begin
        r_im_req  <= 1'b0;
      end

      if (w_load_ir_mem) begin
        r_ir       <= im_rdata;
        r_ir_valid <= 1'b1;
      end else if (w_load_ir_buf) begin
        r_ir       <= r_buf;
        r_ir_valid <= 1'b1;
      end

      if (w_load_buf) r_buf <= im_rdata;

      if (w_pend_clr)      r_pending <= 1'b0;
      else if (w_pend_set) r_pending <= 1'b1;
    end
  end

  assign im_req      = r_im_req;
  assign im_addr     = r_im_addr;
  assign ir          = r_ir;
  assign ir_valid    = r_ir_valid;
  assign pc          = r_pc;
  assign fetch_stall = r_pending | (enable_fetch & (r_state == S_WAIT) & ~im_ack);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, hand-written multi-cycle sequences, then random traffic vs. a transaction-level model.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        IM_enable = 1'b0, IM_read = 1'b0, enable_fetch = 1'b0, enable_pc = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        im_req;
  logic [9:0]  im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [9:0]  pc;
  logic        fetch_stall;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.PC_WIDTH(10), .RESET_PC(10'h000)) dut (
    .clock(clock), .reset(reset),
    .IM_enable(IM_enable), .IM_read(IM_read),
    .enable_fetch(enable_fetch), .enable_pc(enable_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .ir(ir), .ir_valid(ir_valid), .pc(pc), .fetch_stall(fetch_stall)
  );

  always #5 clock = ~clock;

  // ctl = {IM_enable, IM_read, enable_fetch, enable_pc, redirect_valid}; flg = {im_req, ir_valid, fetch_stall}
  typedef struct {
    logic [4:0]  ctl;
    logic [9:0]  rpc;
    logic        ack;
    logic [31:0] rdata;
    logic [2:0]  flg;
    logic [9:0]  addr;
    logic [31:0] ir;
    logic [9:0]  pc;
  } vec_t;

  vec_t tbl[$];

  // Transaction-level reference state
  logic [9:0]  m_pc, m_addr;
  logic [31:0] m_ir, m_word;
  logic        m_irv, m_inflight, m_flushed, m_held, m_waiting;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [4:0] c, input logic [9:0] rp, input logic a, input logic [31:0] d);
    {IM_enable, IM_read, enable_fetch, enable_pc, redirect_valid} = c;
    redirect_pc = rp;
    im_ack      = a;
    im_rdata    = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    set_in(5'b00000, 10'h0, 1'b0, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic model_reset();
    m_pc = 10'h000; m_addr = 10'h000; m_ir = 32'h0; m_word = 32'h0; m_irv = 1'b0;
    m_inflight = 1'b0; m_flushed = 1'b0; m_held = 1'b0; m_waiting = 1'b0;
  endtask

  // Abstract view: one outstanding request (possibly flushed), at most one held word, one owed strobe.
  task automatic model_step();
    logic ack_eff;
    logic idle;
    ack_eff = im_ack && m_inflight;
    idle    = !m_inflight && !m_held;
    if (redirect_valid) begin
      m_pc      = redirect_pc & 10'h3FC;
      m_waiting = 1'b0;
      m_held    = 1'b0;
      if (m_inflight && ack_eff) begin
        m_inflight = 1'b0;
        m_flushed  = 1'b0;
      end else if (m_inflight) begin
        m_flushed = 1'b1;
      end
    end else begin
      if (idle && IM_enable && IM_read) begin
        m_inflight = 1'b1;
        m_addr     = m_pc;
      end else if (m_inflight && m_flushed) begin
        if (ack_eff) begin
          m_inflight = 1'b0;
          m_flushed  = 1'b0;
        end
      end else if (m_inflight) begin
        if (ack_eff) begin
          m_inflight = 1'b0;
          if (m_waiting || enable_fetch) begin
            m_ir = im_rdata; m_irv = 1'b1; m_waiting = 1'b0;
          end else begin
            m_held = 1'b1; m_word = im_rdata;
          end
        end else if (enable_fetch) begin
          m_waiting = 1'b1;
        end
      end else if (m_held && enable_fetch) begin
        m_ir = m_word; m_irv = 1'b1; m_held = 1'b0;
      end
      if (enable_pc) m_pc = 10'(m_pc + 10'd4);
    end
  endtask

  initial begin
    int stall_cnt;

    // Reset state
    set_in(5'b00000, 10'h0, 1'b0, 32'h0);
    @(negedge clock);
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    reset = 1'b1;
    next_cycle();

    // Zero-wait fetch, ack-before-strobe with FULL hold, pc wrap, redirect vs enable_pc
    tbl.push_back('{5'b00000, 10'h000, 1'b0, 32'h0,        3'b000, 10'h000, 32'h0,        10'h000});
    tbl.push_back('{5'b11000, 10'h000, 1'b0, 32'h0,        3'b000, 10'h000, 32'h0,        10'h000});
    tbl.push_back('{5'b00110, 10'h000, 1'b1, 32'h20,       3'b100, 10'h000, 32'h0,        10'h000});
    tbl.push_back('{5'b00000, 10'h000, 1'b0, 32'h0,        3'b010, 10'h000, 32'h20,       10'h004});
    tbl.push_back('{5'b11000, 10'h000, 1'b0, 32'h0,        3'b010, 10'h000, 32'h20,       10'h004});
    tbl.push_back('{5'b00000, 10'h000, 1'b1, 32'hDEADBEEF, 3'b110, 10'h004, 32'h20,       10'h004});
    tbl.push_back('{5'b11000, 10'h000, 1'b0, 32'h0,        3'b010, 10'h004, 32'h20,       10'h004});
    tbl.push_back('{5'b00000, 10'h000, 1'b1, 32'h11111111, 3'b010, 10'h004, 32'h20,       10'h004});
    tbl.push_back('{5'b00100, 10'h000, 1'b0, 32'h0,        3'b010, 10'h004, 32'h20,       10'h004});
    tbl.push_back('{5'b00000, 10'h000, 1'b0, 32'h0,        3'b010, 10'h004, 32'hDEADBEEF, 10'h004});
    tbl.push_back('{5'b00001, 10'h3FF, 1'b0, 32'h0,        3'b010, 10'h004, 32'hDEADBEEF, 10'h004});
    tbl.push_back('{5'b00010, 10'h000, 1'b0, 32'h0,        3'b010, 10'h004, 32'hDEADBEEF, 10'h3FC});
    tbl.push_back('{5'b00011, 10'h040, 1'b0, 32'h0,        3'b010, 10'h004, 32'hDEADBEEF, 10'h000});
    tbl.push_back('{5'b00000, 10'h000, 1'b0, 32'h0,        3'b010, 10'h004, 32'hDEADBEEF, 10'h040});
    tbl.push_back('{5'b00100, 10'h000, 1'b0, 32'h0,        3'b010, 10'h004, 32'hDEADBEEF, 10'h040});
    tbl.push_back('{5'b00000, 10'h000, 1'b0, 32'h0,        3'b010, 10'h004, 32'hDEADBEEF, 10'h040});

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].ctl, tbl[i].rpc, tbl[i].ack, tbl[i].rdata);
      @(negedge clock);
      chk($sformatf("vec%0d_im_req", i), 32'(im_req), 32'(tbl[i].flg[2]));
      chk($sformatf("vec%0d_ir_valid", i), 32'(ir_valid), 32'(tbl[i].flg[1]));
      chk($sformatf("vec%0d_stall", i), 32'(fetch_stall), 32'(tbl[i].flg[0]));
      chk($sformatf("vec%0d_im_addr", i), 32'(im_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_ir", i), ir, tbl[i].ir);
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      next_cycle();
    end

    // Three wait states, strobe one cycle after im_req rises
    set_in(5'b11000, 10'h0, 1'b0, 32'h0);
    next_cycle();
    stall_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      set_in((c == 2) ? 5'b00100 : 5'b00000, 10'h0, (c == 4), 32'hCAFE0001);
      @(negedge clock);
      if (fetch_stall) stall_cnt++;
      if (c == 4) chk("ws_ir_before_ack_edge", ir, 32'hDEADBEEF);
      next_cycle();
    end
    set_in(5'b00000, 10'h0, 1'b0, 32'h0);
    @(negedge clock);
    chk("ws_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("ws_ir", ir, 32'hCAFE0001);
    chk("ws_im_req", 32'(im_req), 32'd0);
    chk("ws_stall_after", 32'(fetch_stall), 32'd0);
    next_cycle();

    // Redirect during WAIT: drain, discard returned word, refetch from new target
    set_in(5'b11000, 10'h0, 1'b0, 32'h0);   next_cycle();
    set_in(5'b00000, 10'h0, 1'b0, 32'h0);   next_cycle();
    set_in(5'b00001, 10'h107, 1'b0, 32'h0); next_cycle();
    set_in(5'b00000, 10'h0, 1'b0, 32'h0);
    @(negedge clock);
    chk("rd_pc", 32'(pc), 32'h104);
    chk("rd_drain_req", 32'(im_req), 32'd1);
    chk("rd_drain_addr", 32'(im_addr), 32'h040);
    next_cycle();
    set_in(5'b00100, 10'h0, 1'b0, 32'h0);
    @(negedge clock);
    chk("rd_drain_stall", 32'(fetch_stall), 32'd0);
    next_cycle();
    set_in(5'b00000, 10'h0, 1'b1, 32'hBAD0BAD0); next_cycle();
    set_in(5'b11000, 10'h0, 1'b0, 32'h0);
    @(negedge clock);
    chk("rd_req_cleared", 32'(im_req), 32'd0);
    chk("rd_ir_kept", ir, 32'hCAFE0001);
    next_cycle();
    set_in(5'b00100, 10'h0, 1'b1, 32'h00000055);
    @(negedge clock);
    chk("rd_new_req", 32'(im_req), 32'd1);
    chk("rd_new_addr", 32'(im_addr), 32'h104);
    next_cycle();
    set_in(5'b00000, 10'h0, 1'b0, 32'h0);
    @(negedge clock);
    chk("rd_new_ir", ir, 32'h00000055);
    next_cycle();

    // Reset asserted mid-fetch, then a late ack
    set_in(5'b11000, 10'h0, 1'b0, 32'h0); next_cycle();
    set_in(5'b00000, 10'h0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("mr_im_req", 32'(im_req), 32'd0);
    chk("mr_im_addr", 32'(im_addr), 32'd0);
    chk("mr_ir", ir, 32'd0);
    chk("mr_ir_valid", 32'(ir_valid), 32'd0);
    chk("mr_pc", 32'(pc), 32'd0);
    @(negedge clock);
    set_in(5'b00100, 10'h0, 1'b1, 32'hFFFFFFFF);
    next_cycle();
    @(negedge clock);
    reset = 1'b1;
    next_cycle();
    @(negedge clock);
    chk("mr_late_ack_req", 32'(im_req), 32'd0);
    chk("mr_late_ack_irv", 32'(ir_valid), 32'd0);
    chk("mr_late_ack_ir", ir, 32'd0);
    next_cycle();

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      IM_enable      = ($urandom_range(0, 1) == 0);
      IM_read        = ($urandom_range(0, 3) != 0);
      enable_fetch   = ($urandom_range(0, 3) == 0);
      enable_pc      = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 10'($urandom);
      im_ack         = ($urandom_range(0, 2) == 0);
      im_rdata       = $urandom;
      @(negedge clock);
      chk("rnd_im_req", 32'(im_req), 32'(m_inflight));
      chk("rnd_im_addr", 32'(im_addr), 32'(m_addr));
      chk("rnd_ir", ir, m_ir);
      chk("rnd_ir_valid", 32'(ir_valid), 32'(m_irv));
      chk("rnd_pc", 32'(pc), 32'(m_pc));
      chk("rnd_stall", 32'(fetch_stall),
          32'(m_waiting | (enable_fetch & m_inflight & ~m_flushed & ~im_ack)));
      @(posedge clock);
      model_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly upstream of the multi-cycle controller. It owns the program counter, issues one instruction-memory read per controller fetch cycle over a level req/ack handshake, buffers the returned word, and presents it as `ir` to the controller and datapath when `enable_fetch` is pulsed. It adds stall reporting for slow memories and a redirect path that flushes an in-flight fetch.

## Interface

Parameters:
- PC_WIDTH, 10: byte-address width of `pc` and `im_addr`.
- RESET_PC, 0: value loaded into `pc` on reset. Bits [1:0] must be 0.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- IM_enable  in  1  controller fetch request qualifier.
- IM_read  in  1  controller read request; a fetch starts when IM_enable & IM_read.
- enable_fetch  in  1  controller strobe: load `ir` from fetched word.
- enable_pc  in  1  controller strobe: advance `pc` by 4.
- redirect_valid  in  1  load `pc` from `redirect_pc`, flush in-flight fetch.
- redirect_pc  in  PC_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- im_req  out  1  memory read request, level, registered.
- im_addr  out  PC_WIDTH  memory address, stable while im_req = 1.
- im_ack  in  1  memory response; sampled only while im_req = 1.
- im_rdata  in  32  read data, valid with im_ack.
- ir  out  32  current instruction register.
- ir_valid  out  1  `ir` holds a fetched word (not the reset value).
- pc  out  PC_WIDTH  current program counter.
- fetch_stall  out  1  enable_fetch was received but data has not returned.

## Operation

- States: IDLE, WAIT, FULL, DRAIN; 2-bit registered state; reset to IDLE.
- IDLE:
  - IM_enable & IM_read: im_addr <= pc, im_req <= 1, go to WAIT.
  - enable_fetch with no data held: ignored; `ir` unchanged.
- WAIT (im_req = 1):
  - im_ack & (pending | enable_fetch): ir <= im_rdata, ir_valid <= 1, pending <= 0, im_req <= 0, go to IDLE.
  - im_ack otherwise: buf <= im_rdata, im_req <= 0, go to FULL.
  - enable_fetch without im_ack: pending <= 1.
- FULL: on enable_fetch, ir <= buf, ir_valid <= 1, go to IDLE.
- DRAIN: im_req held at 1 because the issued request must complete. On im_ack, data is discarded, im_req <= 0, go to IDLE.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; pending <= 0.
  - WAIT without im_ack: go to DRAIN.
  - WAIT with im_ack: drop data, go to IDLE.
  - FULL: drop buf, go to IDLE.
  - `ir` and `ir_valid` are unchanged.
- enable_pc without redirect: pc <= pc + 4, modulo 2^PC_WIDTH (wraps to 0). It is independent of fetch state.
- IM_enable & IM_read outside IDLE: ignored; no second outstanding request ever exists.
- fetch_stall = pending | (enable_fetch & state==WAIT & ~im_ack). It is combinational.
- Reset values:
  - state IDLE, pc = RESET_PC, im_addr = 0, im_req = 0.
  - ir = 0, ir_valid = 0, buf = 0, pending = 0, fetch_stall = 0.
- Reset asserted mid-fetch aborts the transaction immediately. A late im_ack after reset is ignored because im_req = 0.

## Timing

- im_req rises on the edge after the IM_enable & IM_read cycle. im_addr is captured at that same edge.
- With a zero-wait memory (im_ack combinational on im_req), the controller sequence is:
  - S0 issues the request.
  - S1 sees im_ack with enable_fetch; `ir` updates at the end of S1 and is valid in S2.
  - pc+4 is also visible in S2.
  - Total fetch latency: 2 cycles from IM_enable.
- N wait cycles add N cycles. fetch_stall is high for each of those cycles after enable_fetch.
- The im_ack cycle always ends im_req (or starts IDLE from DRAIN). Back-to-back im_ack without a new request is ignored.
- Redirect and enable_pc in the same cycle: the redirect wins; no +4 is applied.

## Test plan

- Zero-wait memory (im_ack = im_req, rdata = 0x0000_0020), controller S0/S1 sequence, pc = 0 -> ir = 0x20 and ir_valid = 1 in the cycle after S1; pc = 4.
- Memory with 3 wait states, enable_fetch one cycle after im_req -> fetch_stall high for exactly 3 cycles; ir updates on the im_ack edge.
- im_ack before enable_fetch (data 0xDEAD_BEEF), enable_fetch 2 cycles later -> state FULL in between; ir = 0xDEAD_BEEF after the strobe; im_req = 0 throughout.
- redirect_valid with redirect_pc = 0x107 during WAIT with 2 wait states left -> pc = 0x104; DRAIN until im_ack; returned word never reaches ir; next fetch im_addr = 0x104.
- PC_WIDTH = 10, pc = 0x3FC, enable_pc -> pc = 0x000. redirect_valid together with enable_pc, target 0x40 -> pc = 0x40.
- Reset (low) asserted while im_req = 1, then im_ack pulses -> all outputs at reset values; ack ignored; ir_valid = 0.
